// File: rtl/systolic_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// systolic_pkg : state type, default widths and signed-product helper. Rev 1.0
// ---------------------------------------------------------------------------
package systolic_pkg;

  localparam int SYS_DATA_W = 8;
  localparam int SYS_ACC_W  = 24;

  typedef logic [SYS_DATA_W-1:0] data_t;
  typedef logic [SYS_ACC_W-1:0]  acc_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    DRAIN   = 2'd3
  } arr_state_t;

  // Low ACC bits of the product of sign-extended operands equal the
  // sign-extended 2*DATA_W product.
  function automatic acc_t sext_prod(input data_t a, input data_t b);
    acc_t ext_a;
    acc_t ext_b;
    ext_a = {{(SYS_ACC_W-SYS_DATA_W){a[SYS_DATA_W-1]}}, a};
    ext_b = {{(SYS_ACC_W-SYS_DATA_W){b[SYS_DATA_W-1]}}, b};
    return ext_a * ext_b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pe_mac_cell.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pe_mac_cell : weight-stationary signed MAC processing element. Rev 1.0
// ---------------------------------------------------------------------------
module pe_mac_cell #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_w_we,
  input  logic [DATA_W-1:0] i_w_data,
  input  logic              i_adv,
  input  logic [DATA_W-1:0] i_x,
  input  logic [ACC_W-1:0]  i_psum,
  output logic [DATA_W-1:0] o_x,
  output logic [ACC_W-1:0]  o_psum
);

  logic [DATA_W-1:0] r_w;
  logic [DATA_W-1:0] r_x;
  logic [ACC_W-1:0]  r_psum;
  logic [ACC_W-1:0]  w_w_ext;
  logic [ACC_W-1:0]  w_x_ext;
  logic [ACC_W-1:0]  w_prod;

  // Multiplying at ACC_W after sign extension keeps the sum wrapping mod 2^ACC_W.
  assign w_w_ext = {{(ACC_W-DATA_W){r_w[DATA_W-1]}}, r_w};
  assign w_x_ext = {{(ACC_W-DATA_W){i_x[DATA_W-1]}}, i_x};
  assign w_prod  = w_w_ext * w_x_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_w    <= '0;
      r_x    <= '0;
      r_psum <= '0;
    end else begin
      if (i_w_we) begin
        r_w <= i_w_data;
      end
      if (i_adv) begin
        r_x    <= i_x;
        r_psum <= i_psum + w_prod;
      end
    end
  end

  assign o_x    = r_x;
  assign o_psum = r_psum;

endmodule
`default_nettype wire

// File: rtl/systolic_mac_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// systolic_mac_array : NxM weight-stationary MAC grid with load/compute/drain control. Rev 1.0
// ---------------------------------------------------------------------------
module systolic_mac_array
  import systolic_pkg::*;
#(
  parameter int NUM_ROWS = 3,
  parameter int NUM_COLS = 3,
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_load_start,
  input  logic              w_load_valid,
  input  logic [DATA_W-1:0] w_load_data  [NUM_COLS],
  input  logic [DATA_W-1:0] ifmap_col_in [NUM_ROWS],
  input  logic [DATA_W-1:0] ifmap_row_in [NUM_COLS-1],
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  psum_out     [NUM_COLS],
  output logic              psum_valid,
  output logic              busy,
  output logic              done
);

  localparam int               CNT_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NUM_ROWS - 1);

  if (ACC_W < 2*DATA_W) begin : g_chk_acc_w
    $error("systolic_mac_array: ACC_W must be at least 2*DATA_W");
  end
  if (NUM_ROWS < 1 || NUM_COLS < 2) begin : g_chk_dims
    $error("systolic_mac_array: need NUM_ROWS >= 1 and NUM_COLS >= 2");
  end

  arr_state_t          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_done;
  logic [NUM_ROWS-1:0] r_valid;
  logic                w_adv;
  logic                w_fire;
  logic [NUM_ROWS-1:0] w_we;
  logic [DATA_W-1:0]   w_col_x [NUM_ROWS];
  logic [DATA_W-1:0]   w_row_x [NUM_COLS-1];
  logic [DATA_W-1:0]   w_xin   [NUM_ROWS][NUM_COLS];
  logic [DATA_W-1:0]   w_xout  [NUM_ROWS][NUM_COLS];
  logic [ACC_W-1:0]    w_pin   [NUM_ROWS][NUM_COLS];
  logic [ACC_W-1:0]    w_pout  [NUM_ROWS][NUM_COLS];
  logic                w_unused_x;

  assign in_ready = (r_state == COMPUTE) && out_ready;
  assign w_fire   = in_valid && in_ready;
  assign w_adv    = out_ready && ((r_state == COMPUTE) || (r_state == DRAIN));

  // Bubbles and drain cycles push zeros into the edges.
  always_comb begin
    for (int r = 0; r < NUM_ROWS; r++) begin
      w_col_x[r] = w_fire ? ifmap_col_in[r] : '0;
    end
    for (int k = 0; k < NUM_COLS-1; k++) begin
      w_row_x[k] = w_fire ? ifmap_row_in[k] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_load_start) begin
            r_state <= LOAD;
            r_cnt   <= '0;
          end
        end
        LOAD: begin
          if (w_load_valid) begin
            if (r_cnt == C_LAST) begin
              r_cnt   <= '0;
              r_state <= COMPUTE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        COMPUTE: begin
          if (w_fire && in_last) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_adv) begin
            if (r_cnt == C_LAST) begin
              r_cnt   <= '0;
              r_state <= IDLE;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Beat validity travels alongside the psum wavefront, one row per advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (w_adv) begin
      r_valid <= NUM_ROWS'({r_valid, w_fire});
    end
  end

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    assign w_we[r] = (r_state == LOAD) && w_load_valid && (r_cnt == CNT_W'(r));
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
      if (c == 0) begin : g_x_left
        assign w_xin[r][c] = w_col_x[r];
      end else if (r == 0) begin : g_x_top
        assign w_xin[r][c] = w_row_x[c-1];
      end else begin : g_x_diag
        assign w_xin[r][c] = w_xout[r-1][c-1];
      end
      if (r == 0) begin : g_p_top
        assign w_pin[r][c] = '0;
      end else begin : g_p_chain
        assign w_pin[r][c] = w_pout[r-1][c];
      end
      pe_mac_cell #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk      (clk),
        .rst      (rst),
        .i_w_we   (w_we[r]),
        .i_w_data (w_load_data[c]),
        .i_adv    (w_adv),
        .i_x      (w_xin[r][c]),
        .i_psum   (w_pin[r][c]),
        .o_x      (w_xout[r][c]),
        .o_psum   (w_pout[r][c])
      );
    end
  end

  // Bottom-row and right-column ifmap registers feed nothing.
  always_comb begin
    w_unused_x = 1'b0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        w_unused_x = w_unused_x ^ (^w_xout[r][c]);
      end
    end
  end

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_out
    assign psum_out[c] = w_pout[NUM_ROWS-1][c];
  end

  assign psum_valid = r_valid[NUM_ROWS-1];
  assign busy       = (r_state != IDLE);
  assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_systolic_mac_array.sv
`default_nettype none
// tb_systolic_mac_array : randomized scoreboard bench; expected psums come from a
// closed-form diagonal-wavefront sum over the recorded edge history.
module tb_systolic_mac_array;

  localparam int N  = 3;
  localparam int M  = 3;
  localparam int DW = 8;
  localparam int AW = 24;

  typedef struct packed {
    logic [N-1:0][DW-1:0] col;
    logic [M-2:0][DW-1:0] row;
  } edge_t;
  typedef logic [N-1:0][M-1:0][DW-1:0] wmat_t;
  typedef logic [M*AW-1:0]             pvec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          w_load_start = 1'b0;
  logic          w_load_valid = 1'b0;
  logic [DW-1:0] w_load_data  [M];
  logic [DW-1:0] ifmap_col_in [N];
  logic [DW-1:0] ifmap_row_in [M-1];
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic          out_ready = 1'b1;
  logic [AW-1:0] psum_out [M];
  logic          psum_valid;
  logic          busy;
  logic          done;

  systolic_mac_array #(
    .NUM_ROWS (N),
    .NUM_COLS (M),
    .DATA_W   (DW),
    .ACC_W    (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .w_load_start (w_load_start),
    .w_load_valid (w_load_valid),
    .w_load_data  (w_load_data),
    .ifmap_col_in (ifmap_col_in),
    .ifmap_row_in (ifmap_row_in),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .out_ready    (out_ready),
    .psum_out     (psum_out),
    .psum_valid   (psum_valid),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int    n_vec = 0;
  int    n_err = 0;
  int    pops = 0;
  bit    tb_compute = 1'b0;
  int    tb_drain = 0;
  bit    gaps_en = 1'b0;
  bit    stall_en = 1'b0;
  wmat_t wgt;
  edge_t hist[$];
  bit    beat_at[$];
  pvec_t exp_q[$];

  task automatic check(input string name, input pvec_t act, input pvec_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rb();
    return DW'($urandom);
  endfunction

  function automatic edge_t rand_edge();
    edge_t e;
    for (int i = 0; i < N; i++) e.col[i] = rb();
    for (int i = 0; i < M-1; i++) e.row[i] = rb();
    return e;
  endfunction

  // Output column c for the beat injected at advance step k: PE[r][c] sees the
  // value that entered the grid d=min(r,c) diagonal hops earlier.
  function automatic pvec_t model(input int k);
    pvec_t         res;
    int            sum;
    int            d;
    edge_t         e;
    logic [DW-1:0] x;
    res = '0;
    for (int c = 0; c < M; c++) begin
      sum = 0;
      for (int r = 0; r < N; r++) begin
        d = (r < c) ? r : c;
        e = hist[k + r - d];
        if (c == d) x = e.col[r - d];
        else        x = e.row[c - d - 1];
        sum += int'($signed(wgt[r][c])) * int'($signed(x));
      end
      res[c*AW +: AW] = sum[AW-1:0];
    end
    return res;
  endfunction

  task automatic drive_edge(input edge_t e);
    for (int i = 0; i < N; i++) ifmap_col_in[i] = e.col[i];
    for (int i = 0; i < M-1; i++) ifmap_row_in[i] = e.row[i];
  endtask

  // One clock: record the advance step implied by the current inputs, push any
  // result that has become fully determined, then step the clock.
  task automatic tick(output bit fired);
    bit    adv;
    bit    in_drain;
    edge_t e;
    int    s;
    in_drain = (tb_drain > 0);
    adv      = out_ready && (tb_compute || in_drain);
    fired    = in_valid && tb_compute && out_ready;
    if (adv) begin
      for (int i = 0; i < N; i++) e.col[i] = fired ? ifmap_col_in[i] : '0;
      for (int i = 0; i < M-1; i++) e.row[i] = fired ? ifmap_row_in[i] : '0;
      hist.push_back(e);
      beat_at.push_back(fired);
      s = hist.size() - 1;
      if (s >= N-1 && beat_at[s-N+1]) exp_q.push_back(model(s-N+1));
    end
    @(posedge clk); #1;
    if (fired && in_last) begin
      tb_compute = 1'b0;
      tb_drain   = N;
    end else if (in_drain && adv) begin
      tb_drain--;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    w_load_start = 1'b0; w_load_valid = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    tb_compute = 1'b0; tb_drain = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    hist.delete(); beat_at.delete(); exp_q.delete();
  endtask

  task automatic check_idle();
    out_ready = 1'b1;
    #1;
    check("reset psum_valid", pvec_t'(psum_valid), '0);
    check("reset busy", pvec_t'(busy), '0);
    check("reset done", pvec_t'(done), '0);
    check("reset in_ready", pvec_t'(in_ready), '0);
    check("reset psum_out", {psum_out[2], psum_out[1], psum_out[0]}, '0);
  endtask

  task automatic load_weights(input wmat_t w);
    bit f;
    w_load_start = 1'b1;
    tick(f);
    w_load_start = 1'b0;
    check("busy after start", pvec_t'(busy), pvec_t'(1));
    wgt = w;
    for (int r = 0; r < N; r++) begin
      if (gaps_en) begin
        repeat ($urandom_range(0, 2)) begin
          w_load_valid = 1'b0;
          for (int c = 0; c < M; c++) w_load_data[c] = rb();
          tick(f);
        end
      end
      w_load_valid = 1'b1;
      for (int c = 0; c < M; c++) w_load_data[c] = w[r][c];
      tick(f);
    end
    w_load_valid = 1'b0;
    tb_compute   = 1'b1;
  endtask

  task automatic send_beat(input edge_t e, input bit last);
    bit f;
    int guard;
    if (gaps_en) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid  = 1'b0;
        in_last   = 1'($urandom);
        out_ready = 1'($urandom_range(0, 3) != 0);
        drive_edge(rand_edge());
        tick(f);
      end
    end
    in_valid = 1'b1;
    in_last  = last;
    drive_edge(e);
    guard = 0;
    do begin
      out_ready = stall_en ? 1'($urandom_range(0, 3) != 0) : 1'b1;
      tick(f);
      guard++;
    end while (!f && guard < 50);
    if (!f) check("beat accepted within budget", pvec_t'(f), pvec_t'(1));
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic finish_tile();
    bit f;
    int guard;
    w_load_valid = 1'b0; w_load_start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    guard = 0;
    while (tb_drain > 0 && guard < 200) begin
      out_ready = stall_en ? 1'($urandom_range(0, 3) != 0) : 1'b1;
      drive_edge(rand_edge());
      tick(f);
      guard++;
    end
    check("drain finished within budget", pvec_t'(tb_drain), '0);
    check("done pulse", pvec_t'(done), pvec_t'(1));
    check("busy at done", pvec_t'(busy), '0);
  endtask

  task automatic rand_tile(input int nbeats);
    wmat_t w;
    for (int r = 0; r < N; r++) for (int c = 0; c < M; c++) w[r][c] = rb();
    load_weights(w);
    for (int b = 0; b < nbeats; b++) send_beat(rand_edge(), b == nbeats-1);
    finish_tile();
  endtask

  // Scoreboard monitor: compares the queue head whenever an output is presented
  // and retires it only on the accepting handshake.
  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready", pvec_t'(in_ready), pvec_t'(tb_compute && out_ready));
      if (psum_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL psum_valid: got output %h, required none", {psum_out[2], psum_out[1], psum_out[0]});
        end else begin
          check("psum_out", {psum_out[2], psum_out[1], psum_out[0]}, exp_q[0]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            pops++;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    wmat_t w;
    edge_t e;
    edge_t b4;
    bit    f;
    int    pops0;
    for (int c = 0; c < M; c++) w_load_data[c] = '0;
    drive_edge('0);

    do_reset();
    check_idle();

    // Unit weights, single beat: bottom row should read {1,5,10}.
    for (int r = 0; r < N; r++) for (int c = 0; c < M; c++) w[r][c] = 8'd1;
    e.col[0] = 8'd1; e.col[1] = 8'd2; e.col[2] = 8'd3;
    e.row[0] = 8'd4; e.row[1] = 8'd5;
    load_weights(w);
    send_beat(e, 1'b1);
    finish_tile();

    // Back-to-back: start asserted in the done cycle, weights all -1.
    for (int r = 0; r < N; r++) for (int c = 0; c < M; c++) w[r][c] = 8'hFF;
    load_weights(w);
    send_beat(e, 1'b1);
    finish_tile();

    // Four beats with a two-cycle downstream stall while an output is pending.
    pops0 = pops;
    for (int r = 0; r < N; r++) for (int c = 0; c < M; c++) w[r][c] = rb();
    load_weights(w);
    for (int b = 0; b < 3; b++) send_beat(rand_edge(), 1'b0);
    b4 = rand_edge();
    in_valid = 1'b1;
    drive_edge(b4);
    out_ready = 1'b0;
    #1;
    check("valid during stall 1", pvec_t'(psum_valid), pvec_t'(1));
    tick(f);
    check("valid during stall 2", pvec_t'(psum_valid), pvec_t'(1));
    tick(f);
    send_beat(b4, 1'b1);
    finish_tile();
    check("outputs for 4-beat tile", pvec_t'(pops - pops0), pvec_t'(4));

    // Weight writes and load requests while busy must be ignored.
    for (int r = 0; r < N; r++) for (int c = 0; c < M; c++) w[r][c] = rb();
    load_weights(w);
    w_load_valid = 1'b1;
    w_load_start = 1'b1;
    for (int c = 0; c < M; c++) w_load_data[c] = 8'd7;
    for (int b = 0; b < 3; b++) send_beat(rand_edge(), b == 2);
    finish_tile();
    out_ready = 1'b1;
    tick(f);
    check("idle after done", pvec_t'(busy), '0);
    check("done is one cycle", pvec_t'(done), '0);

    // Extreme operands: 0x7F weights against 0x80 on every edge.
    for (int r = 0; r < N; r++) for (int c = 0; c < M; c++) w[r][c] = 8'h7F;
    for (int i = 0; i < N; i++) e.col[i] = 8'h80;
    for (int i = 0; i < M-1; i++) e.row[i] = 8'h80;
    load_weights(w);
    for (int b = 0; b < 3; b++) send_beat(e, b == 2);
    finish_tile();

    // Reset in the middle of a tile, then a fresh tile.
    for (int r = 0; r < N; r++) for (int c = 0; c < M; c++) w[r][c] = rb();
    load_weights(w);
    send_beat(rand_edge(), 1'b0);
    send_beat(rand_edge(), 1'b0);
    do_reset();
    check_idle();
    rand_tile(2);

    // Randomized tiles with input gaps and output back-pressure.
    gaps_en  = 1'b1;
    stall_en = 1'b1;
    for (int t = 0; t < 10; t++) rand_tile(int'($urandom_range(1, 6)));

    gaps_en  = 1'b0;
    stall_en = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick(f);
    check("scoreboard empty", pvec_t'(exp_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
